dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Data-memory front end directly downstream of the datapath: consumes aluout (address), writedata and memwrite, and returns readdata.
- Posts word stores into a small in-order buffer so sw retires in one cycle.
- Forwards buffered data to later lw, and drains stores to a multi-cycle data memory over a req/ack handshake.
- Stalls the datapath only when the buffer is full or a load misses the buffer.

Parameters:
- n, 32, data/address width in bits.
- DEPTH, 4, store-buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  datapath store request this cycle.
- memread  input  1  datapath load request this cycle.
- addr  input  n  byte address from aluout; bits [1:0] ignored.
- writedata  input  n  store data.
- readdata  output  n  load data to datapath, valid when memread=1 and stall=0.
- stall  output  1  datapath must hold pc and instr this cycle.
- buf_empty  output  1  no stores pending or in flight.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  n  word-aligned memory address.
- mem_wdata  output  n  write data.
- mem_rdata  input  n  read data, valid with mem_ack on a read.
- mem_ack  input  1  one-cycle completion pulse; ignored when mem_req=0.

Behaviour:
- Reset (reset=0, async) values:
  - buffer empty, head and tail = 0, state IDLE.
  - stall=0, readdata=0, buf_empty=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - An in-flight memory transaction is abandoned; a late mem_ack is ignored because mem_req=0.
- Word accesses only. Entries compare on addr[n-1:2]. mem_addr = {addr[n-1:2],2'b00}.
- memwrite and memread both high: memwrite wins and memread is ignored.
- Store accept:
  - If count<DEPTH: write {addr, writedata} at tail and advance tail. stall=0, so one-cycle retire.
  - If count==DEPTH: stall=1 and nothing is enqueued. The datapath retries.
  - A drain ack in the same cycle does not release a full stall; the store is accepted next cycle.
- Load hit (any valid entry matches, including the head in flight):
  - readdata = data of the youngest matching entry, combinational, stall=0.
- Load miss: stall=1 until data returns. Loads may bypass non-matching buffered stores.
- FSM:
  - IDLE: on load miss go to RD. Otherwise, if count>0, go to WR with mem_req=1, mem_we=1 and head addr/data.
  - WR: hold mem_req, mem_addr and mem_wdata stable. On mem_ack, pop the head. Then go to RD if a load miss is pending, else WR if more entries remain, else IDLE. mem_req drops for one cycle between transactions.
  - RD: mem_req=1, mem_we=0, mem_addr=load address. On mem_ack, capture mem_rdata into readdata register and go to RDONE.
  - RDONE: stall=0, readdata=captured value, then go to IDLE. Latency for a miss with memory ack at cycle k is k+1 stall cycles.
- A load miss arriving during WR waits for that write's ack (stall held).
- Pointers wrap modulo DEPTH. count tracks 0..DEPTH.
- buf_empty = (count==0) and state is not WR.

Optional Feature:
- Macro STORE_COALESCE_EN.
- Defined: a store whose word address matches a valid non-head entry overwrites that entry's data, with no new entry and no stall even when full. A match only on the head entry while in WR enqueues normally.
- Undefined: every store allocates a new entry.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum sb_state_t {IDLE, WR, RD, RDONE}.
  - typedef struct sb_entry_t {valid, word addr, data}.
  - localparam for the pointer width.
- Sub-module store_fifo: circular buffer with push/pop, count, and a parallel youngest-match lookup port.
- dmem_store_buffer holds the FSM and handshake.

Test Plan:
- Reset release then sw 0x0000000A to addr 0x40 -> stall=0 that cycle. Next cycle mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0x0000000A. Ack after 3 cycles -> buf_empty=1.
- sw 0x11 then 0x22 to addr 0x80, then lw 0x80 before drain -> readdata=0x22, stall=0 (youngest wins).
- Memory ack held off, 5 back-to-back sw with DEPTH=4 -> 5th store sees stall=1 until the first ack, then accepts. Memory receives the 5 writes in order.
- lw 0x100 miss with memory holding 0xDEADBEEF and ack at cycle 2 -> stall high 3 cycles, readdata=0xDEADBEEF in RDONE.
- Load miss issued during an outstanding write -> read request starts only after the write ack. Final memory write contents are correct.
- reset asserted in WR with 2 entries -> mem_req=0 immediately, buf_empty=1. A later mem_ack pulse causes no pop or data change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer.
//   sb_state_t : drain/refill FSM states
//   sb_entry_t : one store-buffer entry at the default 32-bit width
//   ptr_w()    : pointer width for a given entry count
package dmem_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SB_N     = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = ptr_w(SB_DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} sb_state_t;

  typedef struct packed {
    logic            valid;
    logic [SB_N-3:0] waddr;  // word address, byte offset dropped
    logic [SB_N-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// store_fifo: in-order circular store buffer.
//   push/push_waddr/push_data : enqueue at tail
//   pop                        : retire head
//   cw_en/cw_idx/cw_data       : overwrite data of an existing entry
//   lk_waddr -> lk_hit/lk_idx/lk_data/lk_is_head : youngest-match lookup
//   head_waddr/head_data, count : head entry view and occupancy (0..DEPTH)
module store_fifo
  import dmem_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [n-3:0]              push_waddr,
  input  logic [n-1:0]              push_data,
  input  logic                      pop,
  input  logic                      cw_en,
  input  logic [ptr_w(DEPTH)-1:0]   cw_idx,
  input  logic [n-1:0]              cw_data,
  input  logic [n-3:0]              lk_waddr,
  output logic                      lk_hit,
  output logic [ptr_w(DEPTH)-1:0]   lk_idx,
  output logic [n-1:0]              lk_data,
  output logic                      lk_is_head,
  output logic [n-3:0]              head_waddr,
  output logic [n-1:0]              head_data,
  output logic [ptr_w(DEPTH):0]     count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0][n-3:0]   waddr_q, waddr_d;
  logic [DEPTH-1:0][n-1:0]   data_q,  data_d;
  logic [PW-1:0]             head_q,  head_d;
  logic [PW-1:0]             tail_q,  tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic [PW-1:0]             scan;

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (cw_en) data_d[cw_idx] = cw_data;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      waddr_d[tail_q] = push_waddr;
      data_d[tail_q]  = push_data;
      tail_d          = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Scan oldest to youngest; the last match seen is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = head_q;
    lk_data = '0;
    scan    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan = head_q + PW'(i);
      if (valid_q[scan] && waddr_q[scan] == lk_waddr) begin
        lk_hit  = 1'b1;
        lk_idx  = scan;
        lk_data = data_q[scan];
      end
    end
  end

  assign lk_is_head = (lk_idx == head_q);
  assign head_waddr = waddr_q[head_q];
  assign head_data  = data_q[head_q];
  assign count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      waddr_q <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory front end with a posted store buffer.
//   memwrite/memread/addr/writedata : datapath request (store wins if both)
//   readdata/stall                  : load result and datapath hold
//   buf_empty                       : nothing buffered and no write in flight
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack : memory handshake
// Build option STORE_COALESCE_EN: a store matching a buffered non-head entry
// overwrites that entry instead of allocating one (and never stalls).
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic         memread,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic         stall,
  output logic         buf_empty,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  sb_state_t    state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [n-1:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] mem_wdata_q, mem_wdata_d;
  logic [n-1:0] rdata_q, rdata_d;

  logic          st, ld, full, coal, push, pop, load_miss;
  logic [n-3:0]  waddr, head_waddr;
  logic [n-1:0]  head_data, lk_data;
  logic          lk_hit, lk_is_head;
  logic [PW-1:0] lk_idx;
  logic [CW-1:0] count;
  logic          unused_bits;

  assign st    = memwrite;
  assign ld    = memread & ~memwrite;
  assign waddr = addr[n-1:2];
  assign full  = (count == CW'(DEPTH));

`ifdef STORE_COALESCE_EN
  assign coal        = st & lk_hit & ~lk_is_head;
  assign unused_bits = ^addr[1:0];
`else
  assign coal        = 1'b0;
  assign unused_bits = ^{addr[1:0], lk_is_head};
`endif

  // Full is judged on the pre-pop count, so a same-cycle drain ack does not
  // let the store in; it is taken on the retry.
  assign push      = st & ~full & ~coal;
  assign pop       = (state_q == WR) & mem_req_q & mem_ack;
  assign load_miss = ld & ~lk_hit & (state_q != RDONE);
  assign stall     = (st & full & ~coal) | load_miss;
  assign readdata  = (ld & lk_hit) ? lk_data : rdata_q;
  assign buf_empty = (count == '0) && (state_q != WR);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  store_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .push_waddr (waddr),
    .push_data  (writedata),
    .pop        (pop),
    .cw_en      (coal),
    .cw_idx     (lk_idx),
    .cw_data    (writedata),
    .lk_waddr   (waddr),
    .lk_hit     (lk_hit),
    .lk_idx     (lk_idx),
    .lk_data    (lk_data),
    .lk_is_head (lk_is_head),
    .head_waddr (head_waddr),
    .head_data  (head_data),
    .count      (count)
  );

  // In WR/RD a low mem_req_q marks the bubble cycle after a completed
  // transaction; the next request is launched from there.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d    = RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {waddr, 2'b00};
        end else if (count != '0) begin
          state_d     = WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {head_waddr, 2'b00};
          mem_wdata_d = head_data;
        end else if (push) begin
          // Empty buffer: the store being enqueued is the head next cycle.
          state_d     = WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {waddr, 2'b00};
          mem_wdata_d = writedata;
        end
      end
      WR: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {head_waddr, 2'b00};
          mem_wdata_d = head_data;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (load_miss)                   state_d = RD;
          else if (count > CW'(1) || push) state_d = WR;
          else                             state_d = IDLE;
        end
      end
      RD: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {waddr, 2'b00};
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata;
          state_d   = RDONE;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: stimulus queues expected memory
// transactions and load results; the memory model and load monitor pop and
// compare when the DUT presents them.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0, memread = 1'b0;
  logic [31:0] addr = '0, writedata = '0;
  logic [31:0] readdata;
  logic        stall, buf_empty, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dmem_store_buffer #(.n(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
    .buf_empty(buf_empty), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] a; logic [31:0] d; } txn_t;
  txn_t        txq[$];
  logic [31:0] ldq[$];
  logic [31:0] mem [logic [31:0]];
  int          n_chk = 0, n_pass = 0;
  bit          ack_en = 0, manual_ack = 0;
  int          lat = 1, wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Memory model: acks the lat-th request cycle, checks transaction order.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (manual_ack) begin
      mem_ack = 1'b1; manual_ack = 0;
    end else if (mem_req && ack_en) begin
      wcnt++;
      if (wcnt >= lat) begin
        txn_t t;
        mem_ack = 1'b1;
        if (txq.size() == 0) chk("unexpected_txn", mem_addr, 32'hxxxxxxxx);
        else begin
          t = txq.pop_front();
          chk("txn_we", {31'b0, mem_we}, {31'b0, t.we});
          chk("txn_addr", mem_addr, t.a);
          if (mem_we) begin
            chk("txn_wdata", mem_wdata, t.d);
            mem[mem_addr] = mem_wdata;
          end else
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
      end
    end
  end

  // Load monitor: a load completes when presented without stall.
  always @(negedge clk) begin
    if (reset && memread && !memwrite && !stall) begin
      if (ldq.size() == 0) chk("unexpected_load", readdata, 32'hxxxxxxxx);
      else chk("readdata", readdata, ldq.pop_front());
    end
  end

  // Present one request; return number of stalled cycles.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, output int sc);
    memwrite = we; memread = ~we; addr = a; writedata = d; sc = 0;
    @(negedge clk);
    while (stall && sc < 200) begin sc++; @(negedge clk); end
    if (stall) chk("issue_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
  endtask

  task automatic wait_empty(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!buf_empty && cyc < 100);
  endtask

  function automatic txn_t tx(input bit we, input logic [31:0] a, input logic [31:0] d);
    txn_t t; t.we = we; t.a = a; t.d = d; return t;
  endfunction

  initial begin
    int sc, cyc;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h12345678;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_buf_empty", {31'b0, buf_empty}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Single store, request next cycle, ack at third request cycle
    lat = 3; ack_en = 1;
    txq.push_back(tx(1, 32'h40, 32'h0000000A));
    issue(1, 32'h40, 32'h0000000A, sc);
    chk("sw1_stall", sc, 0);
    @(negedge clk);
    chk("sw1_req", {31'b0, mem_req}, 32'd1);
    chk("sw1_we", {31'b0, mem_we}, 32'd1);
    chk("sw1_addr", mem_addr, 32'h40);
    chk("sw1_wdata", mem_wdata, 32'h0000000A);
    wait_empty(cyc);
    chk("sw1_empty_cycles", cyc, 3);
    @(posedge clk); #1;

    // Youngest-match forwarding
    ack_en = 0; lat = 1;
    txq.push_back(tx(1, 32'h80, 32'h11));
    txq.push_back(tx(1, 32'h80, 32'h22));
    issue(1, 32'h80, 32'h11, sc); chk("fwd_sw1_stall", sc, 0);
    issue(1, 32'h81, 32'h22, sc); chk("fwd_sw2_stall", sc, 0);
    ldq.push_back(32'h22);
    issue(0, 32'h80, 32'h0, sc); chk("fwd_lw_stall", sc, 0);
    chk("fwd_not_empty", {31'b0, buf_empty}, 32'd0);
    ack_en = 1;
    wait_empty(cyc); chk("fwd_drained", {31'b0, buf_empty}, 32'd1);
    @(posedge clk); #1;

    // Full buffer: fifth store stalls until the first ack
    ack_en = 0;
    for (int i = 0; i < 5; i++) txq.push_back(tx(1, 32'h200 + 4*i, 32'h100 + i));
    for (int i = 0; i < 4; i++) begin
      issue(1, 32'h200 + 4*i, 32'h100 + i, sc);
      chk("full_fill_stall", sc, 0);
    end
    fork
      issue(1, 32'h210, 32'h104, sc);
      begin repeat (4) @(posedge clk); #1 ack_en = 1; end
    join
    chk("full_5th_stall", sc, 5);
    wait_empty(cyc); chk("full_drained", {31'b0, buf_empty}, 32'd1);
    chk("full_mem_last", mem[32'h210], 32'h104);
    @(posedge clk); #1;

    // Load miss, ack on second request cycle
    lat = 2;
    txq.push_back(tx(0, 32'h100, 32'h0));
    ldq.push_back(32'hDEADBEEF);
    issue(0, 32'h100, 32'h0, sc);
    chk("miss_stall", sc, 3);

    // Load miss behind an outstanding write
    lat = 1; ack_en = 0;
    txq.push_back(tx(1, 32'h300, 32'h55));
    txq.push_back(tx(0, 32'h104, 32'h0));
    issue(1, 32'h300, 32'h55, sc); chk("wr_rd_sw_stall", sc, 0);
    ldq.push_back(32'h12345678);
    fork
      issue(0, 32'h104, 32'h0, sc);
      begin repeat (3) @(posedge clk); #1 ack_en = 1; end
    join
    chk("wr_rd_lw_stall", sc, 6);
    chk("wr_rd_mem", mem[32'h300], 32'h55);
    txq.push_back(tx(0, 32'h300, 32'h0));
    ldq.push_back(32'h55);
    issue(0, 32'h300, 32'h0, sc); chk("readback_stall", sc, 2);

    // Reset while draining with two entries
    ack_en = 0;
    issue(1, 32'h400, 32'h77, sc);
    issue(1, 32'h404, 32'h88, sc);
    @(negedge clk);
    chk("prerst_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_empty", {31'b0, buf_empty}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    manual_ack = 1;
    repeat (3) @(negedge clk);
    chk("late_ack_empty", {31'b0, buf_empty}, 32'd1);
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    ack_en = 1;
    txq.push_back(tx(1, 32'h408, 32'h99));
    issue(1, 32'h408, 32'h99, sc);
    wait_empty(cyc); chk("post_rst_drained", {31'b0, buf_empty}, 32'd1);
    chk("abandoned_not_written", {31'b0, mem.exists(32'h400)}, 32'd0);
    chk("post_rst_mem", mem[32'h408], 32'h99);
    @(posedge clk); #1;
    txq.push_back(tx(0, 32'h404, 32'h0));
    ldq.push_back(32'h0);
    issue(0, 32'h404, 32'h0, sc); chk("post_rst_lw_stall", sc, 2);

    repeat (3) @(negedge clk);
    chk("txq_drained", txq.size(), 0);
    chk("ldq_drained", ldq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
